restador_serial_param: RTL and testbench

RESTADOR_SERIAL_PARAM -- requirements
Module: restador_serial_param

---
 rtl/restador_serial_param.sv | 158 +++++++++++++++
 tb/tb_restador_serial_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/restador_serial_param.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first, through one full adder.
// Define RESTADOR_SAT_EN to saturate Y on signed overflow; the default build wraps modulo 2^WIDTH.
module restador_serial_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef RESTADOR_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        full_add = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             op_r;
    logic             carry_r;

    logic             accept_s;
    logic             last_s;
    logic [1:0]       fa_s;
    logic [WIDTH-1:0] res_s;
    logic             ovf_s;
    logic [WIDTH-1:0] y_s;
    logic             c_s;

    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);

    // Start acceptance, last-bit detection and next-state selection.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_BIT) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: current bit sum, completed result and the flags committed on the last bit.
    always_comb begin
        fa_s         = full_add(a_r[cnt_r], b_r[cnt_r], carry_r);
        res_s        = res_r;
        res_s[cnt_r] = fa_s[0];
        // b_r already holds ~B for subtract, so its sign is the effective operand sign.
        ovf_s        = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (fa_s[0] != a_r[WIDTH-1]);
        c_s          = op_r ? fa_s[1] : ~fa_s[1];
`ifdef RESTADOR_SAT_EN
        if (ovf_s) begin
            y_s = a_r[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            y_s = res_s;
        end
`else
        y_s = res_s;
`endif
    end

    // State, operand latches, serial carry/result and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            op_r    <= 1'b0;
            carry_r <= 1'b0;
            Y       <= {WIDTH{1'b0}};
            Z       <= 1'b0;
            N       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                a_r     <= A;
                b_r     <= op ? B : ~B;
                op_r    <= op;
                carry_r <= ~op;
                cnt_r   <= {CW{1'b0}};
                res_r   <= {WIDTH{1'b0}};
            end else if (state_r == RUN) begin
                carry_r <= fa_s[1];
                res_r   <= res_s;
                cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (last_s) begin
                    Y <= y_s;
                    Z <= (y_s == {WIDTH{1'b0}});
                    N <= y_s[WIDTH-1];
                    C <= c_s;
                    V <= ovf_s;
                end else begin
                    Y <= Y;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_restador_serial_param.sv
// Directed self-checking bench for restador_serial_param at WIDTH=8.
module tb_restador_serial_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Y;
    logic       Z, N, C, V;

    int n_tests = 0;
    int n_fail  = 0;

    restador_serial_param #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .Y(Y), .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       o;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ey;
        logic [3:0] ef;
    } vec_t;

    // One operation: start sampled at the next posedge, then wait (bounded) for done.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] y, output logic [3:0] f,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        y = Y;
        f = {Z, N, C, V};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; A = 8'h00; B = 8'h00;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, Y, Z, N, C, V} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b Y=%h ZNCV=%b%b%b%b, want all 0",
                     busy, done, Y, Z, N, C, V);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        vec_t vt[7];
        logic [7:0] y;
        logic [3:0] f;
        int lat, bcnt;
        vt[0] = '{1'b0, 8'h05, 8'h03, 8'h02, 4'b0000};
        vt[1] = '{1'b0, 8'h03, 8'h05, 8'hFE, 4'b0110};
        vt[2] = '{1'b0, 8'h33, 8'h33, 8'h00, 4'b1000};
`ifdef RESTADOR_SAT_EN
        vt[3] = '{1'b0, 8'h80, 8'h01, 8'h80, 4'b0101};
        vt[4] = '{1'b1, 8'h7F, 8'h01, 8'h7F, 4'b0001};
        vt[6] = '{1'b1, 8'h80, 8'h80, 8'h80, 4'b0111};
`else
        vt[3] = '{1'b0, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vt[4] = '{1'b1, 8'h7F, 8'h01, 8'h80, 4'b0101};
        vt[6] = '{1'b1, 8'h80, 8'h80, 8'h00, 4'b1011};
`endif
        vt[5] = '{1'b1, 8'hFF, 8'h01, 8'h00, 4'b1010};
        for (int k = 0; k < 7; k++) begin
            run_op(vt[k].o, vt[k].a, vt[k].b, y, f, lat, bcnt);
            n_tests++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d, want 8", k, lat);
            end
            n_tests++;
            if (bcnt !== 8) begin
                n_fail++;
                $display("FAIL vec%0d_busy_cycles: got %0d, want 8", k, bcnt);
            end
            n_tests++;
            if (y !== vt[k].ey) begin
                n_fail++;
                $display("FAIL vec%0d_Y: got %h, want %h", k, y, vt[k].ey);
            end
            n_tests++;
            if (f !== vt[k].ef) begin
                n_fail++;
                $display("FAIL vec%0d_ZNCV: got %b, want %b", k, f, vt[k].ef);
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({done, Y, Z, N, C, V} !== {1'b0, vt[6].ey, vt[6].ef}) begin
            n_fail++;
            $display("FAIL hold_after_done: got done=%b Y=%h ZNCV=%b%b%b%b, want done=0 Y=%h ZNCV=%b",
                     done, Y, Z, N, C, V, vt[6].ey, vt[6].ef);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 8'h05; B = 8'h03;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) begin
                start = 1'b1; op = 1'b1; A = 8'h10; B = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL ignore_start_latency: got %0d, want 8", lat);
        end
        n_tests++;
        if ({Y, Z, N, C, V} !== {8'h02, 4'b0000}) begin
            n_fail++;
            $display("FAIL ignore_start_result: got Y=%h ZNCV=%b%b%b%b, want Y=02 ZNCV=0000",
                     Y, Z, N, C, V);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gap;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 8'h05; B = 8'h03;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen || Y !== 8'h02) begin
            n_fail++;
            $display("FAIL b2b_first: got seen=%b Y=%h, want seen=1 Y=02", seen, Y);
        end
        op = 1'b1; A = 8'h10; B = 8'h01;
        gap = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                gap = i;
                break;
            end
        end
        n_tests++;
        if (gap !== 9) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: got %0d, want 9", gap);
        end
        n_tests++;
        if ({Y, Z, N, C, V} !== {8'h11, 4'b0000}) begin
            n_fail++;
            $display("FAIL b2b_second: got Y=%h ZNCV=%b%b%b%b, want Y=11 ZNCV=0000", Y, Z, N, C, V);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [7:0] y;
        logic [3:0] f;
        int lat, bcnt, dcnt;
        @(negedge clk);
        start = 1'b1; op = 1'b1; A = 8'h7F; B = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done, Y, Z, N, C, V} !== 14'b0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b Y=%h ZNCV=%b%b%b%b, want all 0",
                     busy, done, Y, Z, N, C, V);
        end
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        n_tests++;
        if (dcnt !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dcnt);
        end
        run_op(1'b1, 8'h12, 8'h34, y, f, lat, bcnt);
        n_tests++;
        if ({lat, y, f} !== {32'd8, 8'h46, 4'b0000}) begin
            n_fail++;
            $display("FAIL abort_recover: got lat=%0d Y=%h ZNCV=%b, want lat=8 Y=46 ZNCV=0000",
                     lat, y, f);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
